// File: rtl/uart_rx_fifo_if.sv
// Bus bundle between the UART receiver/FIFO and its register-side host.
// The host drives rx, rd and clr_err. The receiver drives everything else.
interface uart_rx_fifo_if #(
   parameter int DATA_BITS  = 8,
   parameter int FIFO_DEPTH = 16
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic                 rx;
   logic                 rd;
   logic                 clr_err;
   logic [DATA_BITS-1:0] rd_data;
   logic                 empty;
   logic                 full;
   logic [CW-1:0]        count;
   logic                 busy;
   logic                 frame_err;
   logic                 parity_err;
   logic                 overrun;
   logic                 irq;

   modport slave (
      input  rx, rd, clr_err,
      output rd_data, empty, full, count, busy, frame_err, parity_err, overrun, irq
   );

   modport master (
      output rx, rd, clr_err,
      input  rd_data, empty, full, count, busy, frame_err, parity_err, overrun, irq
   );
endinterface

// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver with optional parity, sticky error flags and a show-ahead receive FIFO.
// A threshold interrupt is derived from the FIFO fill level.
module uart_rx_fifo #(
   parameter longint CLK_FREQ   = 16000000,
   parameter int     BAUDRATE   = 115200,
   parameter int     OVERSAMPLE = 16,
   parameter int     DATA_BITS  = 8,
   parameter int     PARITY     = 0,
   parameter int     FIFO_DEPTH = 16,
   parameter int     IRQ_LEVEL  = 1
) (
   input  logic           clk,
   input  logic           reset,
   uart_rx_fifo_if.slave  bus
);
   localparam longint BO    = longint'(BAUDRATE) * longint'(OVERSAMPLE);
   localparam longint DIV_R = (CLK_FREQ + BO / 2) / BO;
   localparam int     DIV   = (DIV_R < 1) ? 1 : int'(DIV_R);
   localparam int     DW    = $clog2(DIV + 1);
   localparam int     TW    = $clog2(OVERSAMPLE);
   localparam int     BW    = $clog2(DATA_BITS);
   localparam int     AW    = $clog2(FIFO_DEPTH);
   localparam int     CW    = AW + 1;

   localparam logic [TW-1:0] T_PRE  = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLE / 2);
   localparam logic [TW-1:0] T_POST = TW'(OVERSAMPLE / 2 + 1);
   localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_PARITY = 3'd3;
   localparam logic [2:0] S_STOP   = 3'd4;
   localparam logic [2:0] S_BREAK  = 3'd5;

   logic                 sync1_q, sync2_q, prev_q;
   logic [DW-1:0]        div_q, div_d;
   logic [2:0]           state_q, state_d;
   logic [TW-1:0]        tc_q, tc_d;
   logic [BW-1:0]        bit_q, bit_d;
   logic [1:0]           vote_q;
   logic [DATA_BITS-1:0] shreg_q;
   logic                 par_q;
   logic                 push_q, push_d;
   logic                 set_fe, set_pe, set_ov;
   logic                 fe_q, pe_q, ov_q;

   logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]        wr_ptr_q, rd_ptr_q, rd_nxt;
   logic [CW-1:0]        count_q, count_d;
   logic                 empty_q, full_q, irq_q;
   logic [DATA_BITS-1:0] rd_data_q, rd_data_d;
   logic                 do_push, do_pop;

   logic rx_s, fall, tick, maj, at_mid, at_post, at_last, par_x, par_ok;

   assign rx_s    = sync2_q;
   assign fall    = prev_q & ~rx_s;
   assign tick    = (div_q == DW'(DIV - 1));
   assign at_mid  = tick && (tc_q == T_MID);
   assign at_post = tick && (tc_q == T_POST);
   assign at_last = tick && (tc_q == T_LAST);
   // Majority of the three centre samples; the third is the live one at T_POST.
   assign maj     = (vote_q[0] & vote_q[1]) | (vote_q[0] & rx_s) | (vote_q[1] & rx_s);
   assign par_x   = ^{shreg_q, par_q};
   assign par_ok  = (PARITY == 1) ? par_x : (PARITY == 2) ? ~par_x : 1'b1;

   // Divider restarts on the start edge so bit timing is anchored to that edge.
   always_comb begin
      if ((state_q == S_IDLE && fall) || tick) div_d = '0;
      else                                     div_d = div_q + DW'(1);
   end

   always_comb begin
      state_d = state_q;
      tc_d    = tc_q;
      bit_d   = bit_q;
      push_d  = 1'b0;
      set_fe  = 1'b0;
      set_pe  = 1'b0;
      if (tick && state_q != S_IDLE && state_q != S_BREAK)
         tc_d = (tc_q == T_LAST) ? '0 : tc_q + TW'(1);
      case (state_q)
         S_IDLE: if (fall) begin
            state_d = S_START;
            tc_d    = '0;
         end
         S_START: begin
            if (at_mid && rx_s) state_d = S_IDLE;
            else if (at_last) begin
               state_d = S_DATA;
               bit_d   = '0;
            end
         end
         S_DATA: if (at_last) begin
            if (bit_q == BW'(DATA_BITS - 1)) state_d = (PARITY != 0) ? S_PARITY : S_STOP;
            else                             bit_d   = bit_q + BW'(1);
         end
         S_PARITY: if (at_last) state_d = S_STOP;
         // Leaving at mid-stop lets the next start edge be caught immediately.
         S_STOP: if (at_post) begin
            if (!maj) begin
               set_fe  = 1'b1;
               state_d = S_BREAK;
            end else if (!par_ok) begin
               set_pe  = 1'b1;
               state_d = S_IDLE;
            end else begin
               push_d  = 1'b1;
               state_d = S_IDLE;
            end
         end
         S_BREAK: if (rx_s) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   assign do_pop  = bus.rd & ~empty_q;
   assign do_push = push_q & (~full_q | do_pop);
   assign set_ov  = push_q & full_q & ~do_pop;
   assign rd_nxt  = rd_ptr_q + AW'(1);
   assign count_d = count_q + CW'(do_push) - CW'(do_pop);

   // Show-ahead head: bypass the incoming byte when it becomes the head.
   always_comb begin
      rd_data_d = rd_data_q;
      if (do_pop) begin
         if (count_q == CW'(1)) begin
            if (do_push) rd_data_d = shreg_q;
         end else begin
            rd_data_d = mem[rd_nxt];
         end
      end else if (empty_q && do_push) begin
         rd_data_d = shreg_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q   <= 1'b1;
         sync2_q   <= 1'b1;
         prev_q    <= 1'b1;
         div_q     <= '0;
         state_q   <= S_IDLE;
         tc_q      <= '0;
         bit_q     <= '0;
         push_q    <= 1'b0;
         fe_q      <= 1'b0;
         pe_q      <= 1'b0;
         ov_q      <= 1'b0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         empty_q   <= 1'b1;
         full_q    <= 1'b0;
         irq_q     <= 1'b0;
         rd_data_q <= '0;
      end else begin
         sync1_q   <= bus.rx;
         sync2_q   <= sync1_q;
         prev_q    <= sync2_q;
         div_q     <= div_d;
         state_q   <= state_d;
         tc_q      <= tc_d;
         bit_q     <= bit_d;
         push_q    <= push_d;
         fe_q      <= set_fe | (fe_q & ~bus.clr_err);
         pe_q      <= set_pe | (pe_q & ~bus.clr_err);
         ov_q      <= set_ov | (ov_q & ~bus.clr_err);
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_nxt;
         count_q   <= count_d;
         empty_q   <= (count_d == '0);
         full_q    <= (count_d == CW'(FIFO_DEPTH));
         irq_q     <= (count_d >= CW'(IRQ_LEVEL));
         rd_data_q <= rd_data_d;
      end
   end

   always_ff @(posedge clk) begin
      if (tick && tc_q == T_PRE) vote_q[0] <= rx_s;
      if (tick && tc_q == T_MID) vote_q[1] <= rx_s;
      if (state_q == S_DATA && at_post) shreg_q <= {maj, shreg_q[DATA_BITS-1:1]};
      if (state_q == S_PARITY && at_post) par_q <= maj;
      if (do_push) mem[wr_ptr_q] <= shreg_q;
   end

   assign bus.rd_data    = rd_data_q;
   assign bus.empty      = empty_q;
   assign bus.full       = full_q;
   assign bus.count      = count_q;
   assign bus.busy       = (state_q != S_IDLE);
   assign bus.frame_err  = fe_q;
   assign bus.parity_err = pe_q;
   assign bus.overrun    = ov_q;
   assign bus.irq        = irq_q;
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Parametrised UART receiver with an oversampling front end, optional parity and a configurable-depth receive FIFO.
- Sits in the SoC peripheral region behind the register interface and is driven by the board/bench RX line.
- Replaces the fixed 8N1 single-byte receive path; adds FIFO buffering, parity, error flags and a threshold interrupt.

Parameters:
- CLK_FREQ, 16000000, system clock frequency in Hz.
- BAUDRATE, 115200, line rate in baud.
- OVERSAMPLE, 16, baud ticks per bit; must be even and >= 8.
- DATA_BITS, 8, data bits per frame; legal range 5..8.
- PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even.
- FIFO_DEPTH, 16, FIFO entries; must be a power of 2 and >= 2.
- IRQ_LEVEL, 1, fill level at or above which irq asserts; legal range 1..FIFO_DEPTH.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- rx  in  1  asynchronous serial input; idle high.
- rd  in  1  pop strobe for one entry.
- rd_data  out  DATA_BITS  FIFO head (show-ahead); valid while empty=0.
- empty  out  1  FIFO empty.
- full  out  1  FIFO full.
- count  out  clog2(FIFO_DEPTH)+1  FIFO occupancy.
- busy  out  1  frame reception in progress (state != IDLE).
- frame_err  out  1  sticky: stop bit sampled low.
- parity_err  out  1  sticky: parity mismatch.
- overrun  out  1  sticky: byte dropped because FIFO full.
- clr_err  in  1  clears all three sticky flags.
- irq  out  1  level output: count >= IRQ_LEVEL.

Behaviour:
- Reset (synchronous, one clk): empty=1, full=0, count=0, rd_data=0, busy=0, all error flags 0, irq=0, state=IDLE, FIFO pointers 0, synchroniser flops set to 1. Reset mid-frame abandons the frame; no push occurs.
- rx passes through a 2-flop synchroniser before any use.
- Tick generator: DIV = round(CLK_FREQ/(BAUDRATE*OVERSAMPLE)), minimum 1. Single-cycle tick every DIV clks. The divider free-runs but is restarted on the start-edge detect, so the first tick comes DIV clks after the edge.
- States: IDLE, START, DATA, PARITY, STOP, BREAK. A tick counter tc runs 0..OVERSAMPLE-1 in each bit.
  - IDLE: on a synced falling edge -> START with tc=0.
  - START: at tc=OVERSAMPLE/2, if the sample is high this is a false start -> IDLE (no flag). Otherwise at tc wrap -> DATA.
  - Bit value: majority vote of samples at tc = OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1.
  - DATA: LSB first, DATA_BITS bits. Then -> PARITY if PARITY != 0, else -> STOP.
  - PARITY: odd parity requires XOR(data,parity bit)=1; even parity requires it to be 0.
  - STOP: decision is made at the stop-bit centre (tc = OVERSAMPLE/2+1, after the vote):
    - stop bit low: set frame_err, discard the byte, -> BREAK.
    - parity bad: set parity_err, discard the byte, -> IDLE.
    - otherwise push the byte, -> IDLE.
    - Returning to IDLE at mid-stop allows back-to-back frames.
  - BREAK: wait for synced rx high -> IDLE.
- Push/pop:
  - The push takes effect on the clk after the decision. empty falls and rd_data is valid 1 clk after the push cycle.
  - rd when empty: ignored.
  - Push when full without rd: byte dropped, overrun set, FIFO unchanged.
  - Push and rd in the same cycle when full: both succeed, count unchanged, no overrun.
  - Push and rd in the same cycle when empty: push only; rd is ignored.
  - count, full and empty update on the same edge as the pointers. Pointers wrap modulo FIFO_DEPTH.
  - rd_data reflects the new head the clk after a pop.
- Sticky flags: cleared by clr_err. If clr_err and a new error occur in the same cycle, the set wins.
- irq is registered from count; it updates the same edge as count.

Test Plan:
1. CLK_FREQ=16e6, BAUDRATE=500000, OVERSAMPLE=16 (DIV=2, 32 clk/bit), 8N1: send 0xA5 -> count=1, rd_data=0xA5, empty=0, no error flags; rd pulse -> empty=1 on the next clk.
2. Low glitch of 10 clks on idle rx -> busy pulses then returns to 0; count stays 0; no flags set.
3. PARITY=2: send 0x3C with the correct even parity bit, then 0x3C with the parity bit inverted -> exactly one entry (0x3C) in the FIFO and parity_err=1; clr_err -> parity_err=0.
4. Send 0x55 with the stop bit held low for 3 bit times -> frame_err=1, FIFO stays empty, busy stays 1 until rx returns high, then the next frame 0x12 is received correctly.
5. FIFO_DEPTH=4: send 5 bytes 0x01..0x05 without reading -> full=1, count=4, overrun=1; reads return 0x01..0x04 in order. Repeat with rd asserted in the 0x05 push cycle -> overrun stays 0 and 0x05 is the last entry read.
6. IRQ_LEVEL=2: first byte -> irq=0; second byte -> irq=1; one rd -> irq=0. Assert reset mid-frame -> all outputs at reset values and no spurious byte after release.
